// File: rtl/bcd7_scan_driver_if.sv
// Host-side bundle for the 4-digit 7-segment scan driver: value load and scan outputs.
interface bcd7_scan_driver_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz_blank;
    logic        pending;
    logic        frame_tick;
    logic [11:0] bcd7;

    modport master (
        output load, value, dp, lz_blank,
        input  pending, frame_tick, bcd7
    );

    modport slave (
        input  load, value, dp, lz_blank,
        output pending, frame_tick, bcd7
    );
endinterface

// File: rtl/bcd7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver producing the 12-bit bcd7 bus.
// New values are swapped in only at frame boundaries so a frame never tears.
module bcd7_scan_driver #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    bcd7_scan_driver_if.slave bus
);

    localparam int unsigned      CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [11:0]      OFF_WORD  = ACTIVE_LOW ? 12'hFFF : 12'h000;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow_val;
    logic [3:0]       shadow_dp;
    logic [15:0]      disp_val;
    logic [3:0]       disp_dp;
    logic             pending_q;
    logic             frame_tick_q;
    logic [11:0]      bcd7_q;

    logic             wrap_c;
    logic             bnd_c;
    logic [3:0]       nib_c;
    logic             higher_zero_c;
    logic [6:0]       seg_c;
    logic [3:0]       sel_c;
    logic [11:0]      word_c;
    logic [11:0]      bcd7_nxt_c;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Slot timing and the frame boundary (last cycle of digit 3's slot)
    always_comb begin
        wrap_c = (cnt == CNT_LAST);
        bnd_c  = wrap_c && (idx == 2'd3);
    end

    // Next output word for the current (cnt, idx); leading zeros only blank segments
    always_comb begin
        nib_c         = 4'h0;
        higher_zero_c = 1'b0;
        case (idx)
            2'd0: begin
                nib_c         = disp_val[3:0];
                higher_zero_c = 1'b0;
            end
            2'd1: begin
                nib_c         = disp_val[7:4];
                higher_zero_c = (disp_val[15:4] == 12'h000);
            end
            2'd2: begin
                nib_c         = disp_val[11:8];
                higher_zero_c = (disp_val[15:8] == 8'h00);
            end
            default: begin
                nib_c         = disp_val[15:12];
                higher_zero_c = (disp_val[15:12] == 4'h0);
            end
        endcase
        seg_c      = (bus.lz_blank && higher_zero_c) ? 7'h00 : hex_to_seg(nib_c);
        sel_c      = (cnt >= BLANK_END) ? (4'b0001 << idx) : 4'b0000;
        word_c     = {sel_c, disp_dp[idx], seg_c};
        bcd7_nxt_c = ACTIVE_LOW ? ~word_c : word_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= 2'd0;
            shadow_val   <= 16'h0000;
            shadow_dp    <= 4'h0;
            disp_val     <= 16'h0000;
            disp_dp      <= 4'h0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            bcd7_q       <= OFF_WORD;
        end else begin
            cnt          <= wrap_c ? '0 : cnt + CNT_W'(1);
            idx          <= wrap_c ? idx + 2'd1 : idx;
            frame_tick_q <= bnd_c;
            bcd7_q       <= bcd7_nxt_c;

            // A load on the boundary cycle bypasses the shadow entirely
            if (bnd_c) begin
                if (bus.load) begin
                    disp_val  <= bus.value;
                    disp_dp   <= bus.dp;
                    pending_q <= 1'b0;
                end else if (pending_q) begin
                    disp_val  <= shadow_val;
                    disp_dp   <= shadow_dp;
                    pending_q <= 1'b0;
                end
            end else if (bus.load) begin
                shadow_val <= bus.value;
                shadow_dp  <= bus.dp;
                pending_q  <= 1'b1;
            end
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.bcd7       = bcd7_q;

endmodule

// File: tb/tb_bcd7_scan_driver.sv
// Randomized self-checking bench for bcd7_scan_driver (SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1).
module tb_bcd7_scan_driver;

    localparam int SLOT  = 8;
    localparam int FRAME = 32;
    localparam logic [6:0] HEX_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk;
    logic reset;
    bcd7_scan_driver_if tb_if ();

    bcd7_scan_driver #(
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (tb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: cycles since reset release, displayed and queued values
    int          t;
    logic [15:0] m_val, sh_val;
    logic [3:0]  m_dp, sh_dp;
    logic        m_pend;
    logic [11:0] exp_bcd7;
    logic        exp_pend;
    logic        exp_tick;

    function automatic logic [11:0] model_word(int pos, int slot, logic [15:0] v,
                                               logic [3:0] d, logic lz);
        logic [15:0] upper;
        logic [6:0]  seg;
        logic [3:0]  sel;
        upper = v >> (4 * slot);
        seg   = (lz && slot > 0 && upper == 16'h0) ? 7'h00 : HEX_TAB[upper[3:0]];
        sel   = (pos >= 2) ? 4'(1 << slot) : 4'h0;
        return ~{sel, d[slot], seg};
    endfunction

    // Advance one clock edge, predicting what the outputs must be after it
    task automatic step();
        int pos, slot;
        bit bnd;
        pos      = t % SLOT;
        slot     = (t / SLOT) % 4;
        bnd      = (t % FRAME) == FRAME - 1;
        exp_bcd7 = model_word(pos, slot, m_val, m_dp, tb_if.lz_blank);
        exp_tick = bnd;
        if (tb_if.load) begin
            if (bnd) begin
                m_val  = tb_if.value;
                m_dp   = tb_if.dp;
                m_pend = 1'b0;
            end else begin
                sh_val = tb_if.value;
                sh_dp  = tb_if.dp;
                m_pend = 1'b1;
            end
        end else if (bnd && m_pend) begin
            m_val  = sh_val;
            m_dp   = sh_dp;
            m_pend = 1'b0;
        end
        exp_pend = m_pend;
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_to(int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) step();
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any further edge
    task automatic do_reset(string tag);
        reset    = 1'b1;
        t        = 0;
        m_val    = 16'h0; m_dp  = 4'h0;
        sh_val   = 16'h0; sh_dp = 4'h0;
        m_pend   = 1'b0;
        #2;
        checks++;
        if (tb_if.bcd7 !== 12'hFFF || tb_if.pending !== 1'b0 || tb_if.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL %s_async got bcd7=%h pend=%b tick=%b want FFF 0 0",
                     tag, tb_if.bcd7, tb_if.pending, tb_if.frame_tick);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int p;
        do_reset("reset0");
        for (int i = 0; i < 11; i++) step();
        do_reset("reset_mid");
        for (int i = 0; i < SLOT; i++) begin
            p = t % SLOT;
            step();
            checks++;
            if ({tb_if.bcd7, tb_if.pending, tb_if.frame_tick} !== {exp_bcd7, exp_pend, exp_tick}) begin
                errors++;
                $display("FAIL reset_scan t=%0d got %h %b %b want %h %b %b", t - 1,
                         tb_if.bcd7, tb_if.pending, tb_if.frame_tick, exp_bcd7, exp_pend, exp_tick);
            end
            if (p >= 2) begin
                checks++;
                if (tb_if.bcd7 !== 12'hEC0) begin
                    errors++;
                    $display("FAIL reset_digit0 t=%0d got %h want EC0", t - 1, tb_if.bcd7);
                end
            end
        end
    endtask

    task automatic test_load_basic();
        int p, s;
        idle_to(13);
        tb_if.value = 16'h12AF; tb_if.dp = 4'h0; tb_if.load = 1'b1;
        step();
        tb_if.load = 1'b0;
        for (int i = 0; i < FRAME + 18; i++) begin
            p = t % SLOT;
            s = (t / SLOT) % 4;
            step();
            checks++;
            if ({tb_if.bcd7, tb_if.pending, tb_if.frame_tick} !== {exp_bcd7, exp_pend, exp_tick}) begin
                errors++;
                $display("FAIL load_basic t=%0d got %h %b %b want %h %b %b", t - 1,
                         tb_if.bcd7, tb_if.pending, tb_if.frame_tick, exp_bcd7, exp_pend, exp_tick);
            end
            if (i >= 18) begin
                checks++;
                if ((p < 2 && tb_if.bcd7[11:8] !== 4'hF) ||
                    (p >= 2 && s == 0 && tb_if.bcd7 !== 12'hE8E) ||
                    (p >= 2 && s == 3 && tb_if.bcd7 !== 12'h7F9)) begin
                    errors++;
                    $display("FAIL load_12AF slot=%0d pos=%0d got %h", s, p, tb_if.bcd7);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int p, s;
        idle_to(3);
        tb_if.value = 16'h1111; tb_if.dp = 4'h3; tb_if.load = 1'b1;
        step();
        tb_if.load = 1'b0;
        for (int i = 0; i < 6; i++) step();
        tb_if.value = 16'h2222; tb_if.dp = 4'h0; tb_if.load = 1'b1;
        step();
        tb_if.load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            p = t % SLOT;
            s = (t / SLOT) % 4;
            step();
            checks++;
            if ({tb_if.bcd7, tb_if.pending, tb_if.frame_tick} !== {exp_bcd7, exp_pend, exp_tick}) begin
                errors++;
                $display("FAIL back_to_back t=%0d got %h %b %b want %h %b %b", t - 1,
                         tb_if.bcd7, tb_if.pending, tb_if.frame_tick, exp_bcd7, exp_pend, exp_tick);
            end
            if (i >= 22 && i < 22 + FRAME && p >= 2) begin
                checks++;
                if (tb_if.bcd7 !== ~{4'(1 << s), 1'b0, 7'h5B}) begin
                    errors++;
                    $display("FAIL show_2222 slot=%0d got %h", s, tb_if.bcd7);
                end
            end
        end
    endtask

    task automatic test_lz_blank();
        int p, s;
        tb_if.lz_blank = 1'b1;
        for (int v = 0; v < 2; v++) begin
            idle_to(1);
            tb_if.value = (v == 0) ? 16'h0050 : 16'h0000;
            tb_if.dp = 4'h0; tb_if.load = 1'b1;
            step();
            tb_if.load = 1'b0;
            idle_to(0);
            for (int i = 0; i < FRAME; i++) begin
                p = t % SLOT;
                s = (t / SLOT) % 4;
                step();
                checks++;
                if ({tb_if.bcd7, tb_if.pending, tb_if.frame_tick} !== {exp_bcd7, exp_pend, exp_tick}) begin
                    errors++;
                    $display("FAIL lz_blank t=%0d got %h %b %b want %h %b %b", t - 1,
                             tb_if.bcd7, tb_if.pending, tb_if.frame_tick, exp_bcd7, exp_pend, exp_tick);
                end
                if (p >= 2 && (s >= 2 || (v == 1 && s == 1))) begin
                    checks++;
                    if (tb_if.bcd7 !== {~4'(1 << s), 1'b1, 7'h7F}) begin
                        errors++;
                        $display("FAIL lz_off slot=%0d got %h", s, tb_if.bcd7);
                    end
                end
            end
        end
        tb_if.lz_blank = 1'b0;
    endtask

    task automatic test_bnd_load();
        int ticks;
        idle_to(FRAME - 1);
        tb_if.value = 16'hABCD; tb_if.dp = 4'b0101; tb_if.load = 1'b1;
        step();
        tb_if.load = 1'b0;
        checks++;
        if (tb_if.pending !== 1'b0) begin
            errors++;
            $display("FAIL bnd_load_pending got %b want 0", tb_if.pending);
        end
        ticks = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (tb_if.frame_tick === 1'b1) ticks++;
            checks++;
            if ({tb_if.bcd7, tb_if.pending, tb_if.frame_tick} !== {exp_bcd7, exp_pend, exp_tick}) begin
                errors++;
                $display("FAIL bnd_load t=%0d got %h %b %b want %h %b %b", t - 1,
                         tb_if.bcd7, tb_if.pending, tb_if.frame_tick, exp_bcd7, exp_pend, exp_tick);
            end
        end
        checks++;
        if (ticks !== 3) begin
            errors++;
            $display("FAIL frame_tick_count got %0d want 3", ticks);
        end
    endtask

    task automatic test_reset_pending();
        idle_to(12);
        tb_if.value = 16'hBEEF; tb_if.dp = 4'hF; tb_if.load = 1'b1;
        step();
        tb_if.load = 1'b0;
        step();
        checks++;
        if (tb_if.pending !== 1'b1) begin
            errors++;
            $display("FAIL pend_before_reset got %b want 1", tb_if.pending);
        end
        do_reset("reset_pend");
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++;
            if ({tb_if.bcd7, tb_if.pending, tb_if.frame_tick} !== {exp_bcd7, exp_pend, exp_tick} ||
                tb_if.pending !== 1'b0) begin
                errors++;
                $display("FAIL reset_pending t=%0d got %h %b %b want %h 0 %b", t - 1,
                         tb_if.bcd7, tb_if.pending, tb_if.frame_tick, exp_bcd7, exp_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tb_if.load  = ($urandom_range(0, 9) == 0);
            tb_if.value = 16'($urandom);
            if ($urandom_range(0, 2) == 0) tb_if.value[15:8] = 8'h00;
            tb_if.dp    = 4'($urandom);
            if ($urandom_range(0, 15) == 0) tb_if.lz_blank = ~tb_if.lz_blank;
            step();
            checks++;
            if ({tb_if.bcd7, tb_if.pending, tb_if.frame_tick} !== {exp_bcd7, exp_pend, exp_tick}) begin
                errors++;
                $display("FAIL random t=%0d got %h %b %b want %h %b %b", t - 1,
                         tb_if.bcd7, tb_if.pending, tb_if.frame_tick, exp_bcd7, exp_pend, exp_tick);
            end
        end
        tb_if.load = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        tb_if.load     = 1'b0;
        tb_if.value    = 16'h0000;
        tb_if.dp       = 4'h0;
        tb_if.lz_blank = 1'b0;
        t      = 0;
        m_pend = 1'b0;
        test_reset();
        test_load_basic();
        test_back_to_back();
        test_lz_blank();
        test_bnd_load();
        test_reset_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
